// File: rtl/cntr_req_arbiter.sv
// Counter increment request arbiter: holds per-cell plus/minus pending flags
// and offers them one at a time, lowest cell first, to the counter-cycle logic.
//
// Ports:
//   CLOCK      system clock, rising edge
//   SIM_RST_n  asynchronous active-low reset
//   REQ_PLUS   per-cell plus-increment request pulses
//   REQ_MINUS  per-cell minus-increment request pulses
//   CTR_ACK    one-clock accept of the current offer
//   OVR_CLR    clears all overrun flags
//   CTROR      offer valid
//   CELL_ADR   cell index of the current offer
//   PINC       offer is a plus increment
//   MINC       offer is a minus increment
//   OVR        sticky per-cell overrun flags
module cntr_req_arbiter #(
   parameter int NCELL = 20,
   parameter int AW    = 5
) (
   input  logic             CLOCK,
   input  logic             SIM_RST_n,
   input  logic [NCELL-1:0] REQ_PLUS,
   input  logic [NCELL-1:0] REQ_MINUS,
   input  logic             CTR_ACK,
   input  logic             OVR_CLR,
   output logic             CTROR,
   output logic [AW-1:0]    CELL_ADR,
   output logic             PINC,
   output logic             MINC,
   output logic [NCELL-1:0] OVR
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OFFER  = 2'd1,
      RETIRE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [NCELL-1:0] pp;
   logic [NCELL-1:0] pm;
   logic [NCELL-1:0] pp_nxt;
   logic [NCELL-1:0] pm_nxt;
   logic [NCELL-1:0] ovr_set;
   logic [NCELL-1:0] ovr_nxt;
   logic [NCELL-1:0] offered;

   logic             ack;
   logic             any_pend;
   logic [AW-1:0]    low_idx;
   logic             low_plus;
   logic             low_minus;

   logic             ctror_nxt;
   logic [AW-1:0]    adr_nxt;
   logic             pinc_nxt;
   logic             minc_nxt;

   // CTROR is high exactly while in OFFER, so it qualifies the offered cell.
   assign ack = CTR_ACK && (state == OFFER);

   always_comb begin
      offered = '0;
      for (int i = 0; i < NCELL; i++) begin
         offered[i] = CTROR && (CELL_ADR == AW'(i));
      end
   end

   // Request capture against the registered pending flags.
   always_comb begin
      pp_nxt  = pp;
      pm_nxt  = pm;
      ovr_set = '0;
      for (int i = 0; i < NCELL; i++) begin
         if (ack && offered[i]) begin
            if (PINC) begin
               pp_nxt[i] = 1'b0;
            end
            if (MINC) begin
               pm_nxt[i] = 1'b0;
            end
         end
         if (REQ_PLUS[i] && !REQ_MINUS[i]) begin
            if (pm[i]) begin
               // the offered cell cannot be cancelled under the core
               if (offered[i]) begin
                  ovr_set[i] = 1'b1;
               end else begin
                  pm_nxt[i] = 1'b0;
               end
            end else if (pp[i]) begin
               // a flag being retired this clock can be re-armed
               if (ack && offered[i]) begin
                  pp_nxt[i] = 1'b1;
               end else begin
                  ovr_set[i] = 1'b1;
               end
            end else begin
               pp_nxt[i] = 1'b1;
            end
         end else if (REQ_MINUS[i] && !REQ_PLUS[i]) begin
            if (pp[i]) begin
               if (offered[i]) begin
                  ovr_set[i] = 1'b1;
               end else begin
                  pp_nxt[i] = 1'b0;
               end
            end else if (pm[i]) begin
               if (ack && offered[i]) begin
                  pm_nxt[i] = 1'b1;
               end else begin
                  ovr_set[i] = 1'b1;
               end
            end else begin
               pm_nxt[i] = 1'b1;
            end
         end
      end
   end

   // A same-clock overrun wins over the clear.
   always_comb begin
      ovr_nxt = (OVR_CLR ? '0 : OVR) | ovr_set;
   end

   // Lowest-index pending cell; scanning downward leaves the lowest hit.
   always_comb begin
      any_pend  = |(pp | pm);
      low_idx   = '0;
      low_plus  = 1'b0;
      low_minus = 1'b0;
      for (int i = NCELL - 1; i >= 0; i--) begin
         if (pp[i] || pm[i]) begin
            low_idx   = AW'(i);
            low_plus  = pp[i];
            low_minus = pm[i];
         end
      end
   end

   always_ff @(posedge CLOCK or negedge SIM_RST_n) begin
      if (!SIM_RST_n) begin
         state    <= IDLE;
         pp       <= '0;
         pm       <= '0;
         OVR      <= '0;
         CTROR    <= 1'b0;
         CELL_ADR <= '0;
         PINC     <= 1'b0;
         MINC     <= 1'b0;
      end else begin
         state    <= state_nxt;
         pp       <= pp_nxt;
         pm       <= pm_nxt;
         OVR      <= ovr_nxt;
         CTROR    <= ctror_nxt;
         CELL_ADR <= adr_nxt;
         PINC     <= pinc_nxt;
         MINC     <= minc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (any_pend) begin
               state_nxt = OFFER;
            end
         end
         OFFER: begin
            if (CTR_ACK) begin
               state_nxt = RETIRE;
            end
         end
         RETIRE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Offer outputs are registered; they are held until the next decision.
   always_comb begin
      ctror_nxt = CTROR;
      adr_nxt   = CELL_ADR;
      pinc_nxt  = PINC;
      minc_nxt  = MINC;
      unique case (state)
         IDLE: begin
            ctror_nxt = 1'b0;
            pinc_nxt  = 1'b0;
            minc_nxt  = 1'b0;
            if (any_pend) begin
               ctror_nxt = 1'b1;
               adr_nxt   = low_idx;
               pinc_nxt  = low_plus;
               minc_nxt  = low_minus;
            end
         end
         OFFER: begin
            if (CTR_ACK) begin
               ctror_nxt = 1'b0;
               pinc_nxt  = 1'b0;
               minc_nxt  = 1'b0;
            end
         end
         RETIRE: begin
            ctror_nxt = 1'b0;
            pinc_nxt  = 1'b0;
            minc_nxt  = 1'b0;
         end
         default: begin
            ctror_nxt = 1'b0;
            pinc_nxt  = 1'b0;
            minc_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_cntr_req_arbiter.sv
// Directed bench for cntr_req_arbiter: reset, single offer, priority,
// cancel, overrun and reset-during-offer scenarios.
module tb_cntr_req_arbiter;

   localparam int NCELL = 20;
   localparam int AW    = 5;

   logic             CLOCK;
   logic             SIM_RST_n;
   logic [NCELL-1:0] REQ_PLUS;
   logic [NCELL-1:0] REQ_MINUS;
   logic             CTR_ACK;
   logic             OVR_CLR;
   logic             CTROR;
   logic [AW-1:0]    CELL_ADR;
   logic             PINC;
   logic             MINC;
   logic [NCELL-1:0] OVR;

   int checks = 0;
   int errors = 0;

   cntr_req_arbiter #(.NCELL(NCELL), .AW(AW)) dut (
      .CLOCK     (CLOCK),
      .SIM_RST_n (SIM_RST_n),
      .REQ_PLUS  (REQ_PLUS),
      .REQ_MINUS (REQ_MINUS),
      .CTR_ACK   (CTR_ACK),
      .OVR_CLR   (OVR_CLR),
      .CTROR     (CTROR),
      .CELL_ADR  (CELL_ADR),
      .PINC      (PINC),
      .MINC      (MINC),
      .OVR       (OVR)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic test_reset();
      SIM_RST_n = 1'b0;
      REQ_PLUS  = '1;
      REQ_MINUS = '0;
      CTR_ACK   = 1'b0;
      OVR_CLR   = 1'b0;
      repeat (3) step();
      checks++; if (CTROR !== 1'b0) begin errors++; $display("FAIL rst_ctror got %0h exp 0", CTROR); end
      checks++; if (PINC !== 1'b0 || MINC !== 1'b0) begin errors++; $display("FAIL rst_pm got %0b%0b exp 00", PINC, MINC); end
      checks++; if (CELL_ADR !== 5'd0) begin errors++; $display("FAIL rst_adr got %0h exp 0", CELL_ADR); end
      checks++; if (OVR !== 20'h0) begin errors++; $display("FAIL rst_ovr got %0h exp 0", OVR); end
      REQ_PLUS  = '0;
      SIM_RST_n = 1'b1;
      repeat (4) step();
      checks++; if (CTROR !== 1'b0) begin errors++; $display("FAIL rst_idle got %0h exp 0", CTROR); end
   endtask

   task automatic test_single();
      REQ_PLUS[3] = 1'b1;
      step();
      REQ_PLUS = '0;
      checks++; if (CTROR !== 1'b0) begin errors++; $display("FAIL single_lat1 got %0h exp 0", CTROR); end
      step();
      checks++; if (CTROR !== 1'b1) begin errors++; $display("FAIL single_ctror got %0h exp 1", CTROR); end
      checks++; if (CELL_ADR !== 5'd3) begin errors++; $display("FAIL single_adr got %0d exp 3", CELL_ADR); end
      checks++; if (PINC !== 1'b1 || MINC !== 1'b0) begin errors++; $display("FAIL single_pm got %0b%0b exp 10", PINC, MINC); end
      step();
      step();
      checks++; if (CTROR !== 1'b1 || CELL_ADR !== 5'd3) begin errors++; $display("FAIL single_hold got %0h/%0d exp 1/3", CTROR, CELL_ADR); end
      CTR_ACK = 1'b1;
      step();
      CTR_ACK = 1'b0;
      checks++; if (CTROR !== 1'b0 || PINC !== 1'b0) begin errors++; $display("FAIL single_ack got %0b%0b exp 00", CTROR, PINC); end
      step();
      checks++; if (CTROR !== 1'b0) begin errors++; $display("FAIL single_retire got %0h exp 0", CTROR); end
      // acknowledge while idle must be ignored
      CTR_ACK = 1'b1;
      step();
      CTR_ACK = 1'b0;
      step();
      step();
      checks++; if (CTROR !== 1'b0) begin errors++; $display("FAIL single_after got %0h exp 0", CTROR); end
   endtask

   task automatic test_priority();
      REQ_MINUS[7] = 1'b1;
      step();
      REQ_MINUS   = '0;
      REQ_PLUS[2] = 1'b1;
      step();
      REQ_PLUS = '0;
      checks++; if (CTROR !== 1'b1 || CELL_ADR !== 5'd7) begin errors++; $display("FAIL prio_first got %0h/%0d exp 1/7", CTROR, CELL_ADR); end
      checks++; if (PINC !== 1'b0 || MINC !== 1'b1) begin errors++; $display("FAIL prio_first_pm got %0b%0b exp 01", PINC, MINC); end
      step();
      step();
      checks++; if (CTROR !== 1'b1 || CELL_ADR !== 5'd7 || MINC !== 1'b1) begin errors++; $display("FAIL prio_nopreempt got %0h/%0d/%0b exp 1/7/1", CTROR, CELL_ADR, MINC); end
      CTR_ACK = 1'b1;
      step();
      CTR_ACK = 1'b0;
      checks++; if (CTROR !== 1'b0) begin errors++; $display("FAIL prio_retire got %0h exp 0", CTROR); end
      step();
      checks++; if (CTROR !== 1'b0) begin errors++; $display("FAIL prio_idle got %0h exp 0", CTROR); end
      step();
      checks++; if (CTROR !== 1'b1 || CELL_ADR !== 5'd2) begin errors++; $display("FAIL prio_second got %0h/%0d exp 1/2", CTROR, CELL_ADR); end
      checks++; if (PINC !== 1'b1 || MINC !== 1'b0) begin errors++; $display("FAIL prio_second_pm got %0b%0b exp 10", PINC, MINC); end
      CTR_ACK = 1'b1;
      step();
      CTR_ACK = 1'b0;
      step();
      step();
      checks++; if (CTROR !== 1'b0) begin errors++; $display("FAIL prio_drain got %0h exp 0", CTROR); end
   endtask

   task automatic test_cancel();
      REQ_PLUS[9] = 1'b1;
      step();
      REQ_PLUS = '0;
      step();
      checks++; if (CTROR !== 1'b1 || CELL_ADR !== 5'd9) begin errors++; $display("FAIL cancel_offer got %0h/%0d exp 1/9", CTROR, CELL_ADR); end
      REQ_PLUS[5] = 1'b1;
      step();
      REQ_PLUS     = '0;
      REQ_MINUS[5] = 1'b1;
      step();
      REQ_MINUS    = '0;
      REQ_PLUS[4]  = 1'b1;
      REQ_MINUS[4] = 1'b1;
      step();
      REQ_PLUS  = '0;
      REQ_MINUS = '0;
      checks++; if (OVR !== 20'h0) begin errors++; $display("FAIL cancel_ovr got %0h exp 0", OVR); end
      checks++; if (CTROR !== 1'b1 || CELL_ADR !== 5'd9) begin errors++; $display("FAIL cancel_hold got %0h/%0d exp 1/9", CTROR, CELL_ADR); end
      CTR_ACK = 1'b1;
      step();
      CTR_ACK = 1'b0;
      step();
      step();
      checks++; if (CTROR !== 1'b0) begin errors++; $display("FAIL cancel_nooffer got %0h/%0d exp 0", CTROR, CELL_ADR); end
      step();
      step();
      checks++; if (CTROR !== 1'b0) begin errors++; $display("FAIL cancel_nooffer2 got %0h/%0d exp 0", CTROR, CELL_ADR); end
   endtask

   task automatic test_overrun();
      REQ_PLUS[1] = 1'b1;
      step();
      step();
      REQ_PLUS = '0;
      checks++; if (OVR !== 20'h2) begin errors++; $display("FAIL ovr_double got %0h exp 2", OVR); end
      checks++; if (CTROR !== 1'b1 || CELL_ADR !== 5'd1 || PINC !== 1'b1) begin errors++; $display("FAIL ovr_offer got %0h/%0d/%0b exp 1/1/1", CTROR, CELL_ADR, PINC); end
      OVR_CLR = 1'b1;
      step();
      OVR_CLR = 1'b0;
      checks++; if (OVR !== 20'h0) begin errors++; $display("FAIL ovr_clr got %0h exp 0", OVR); end
      REQ_MINUS[1] = 1'b1;
      step();
      REQ_MINUS = '0;
      checks++; if (OVR !== 20'h2) begin errors++; $display("FAIL ovr_offered got %0h exp 2", OVR); end
      checks++; if (CTROR !== 1'b1 || CELL_ADR !== 5'd1 || PINC !== 1'b1 || MINC !== 1'b0) begin errors++; $display("FAIL ovr_unchanged got %0h/%0d/%0b%0b exp 1/1/10", CTROR, CELL_ADR, PINC, MINC); end
      REQ_MINUS[1] = 1'b1;
      OVR_CLR      = 1'b1;
      step();
      REQ_MINUS = '0;
      step();
      OVR_CLR = 1'b0;
      checks++; if (OVR !== 20'h0) begin errors++; $display("FAIL ovr_clr2 got %0h exp 0", OVR); end
      REQ_MINUS[1] = 1'b1;
      OVR_CLR      = 1'b1;
      step();
      REQ_MINUS = '0;
      OVR_CLR   = 1'b0;
      checks++; if (OVR !== 20'h2) begin errors++; $display("FAIL ovr_clr_race got %0h exp 2", OVR); end
      OVR_CLR = 1'b1;
      step();
      OVR_CLR = 1'b0;
      // same-type request in the ack clock re-arms without overrun
      CTR_ACK     = 1'b1;
      REQ_PLUS[1] = 1'b1;
      step();
      CTR_ACK  = 1'b0;
      REQ_PLUS = '0;
      checks++; if (CTROR !== 1'b0 || OVR !== 20'h0) begin errors++; $display("FAIL ovr_rearm got %0h/%0h exp 0/0", CTROR, OVR); end
      step();
      checks++; if (CTROR !== 1'b0) begin errors++; $display("FAIL ovr_rearm_idle got %0h exp 0", CTROR); end
      step();
      checks++; if (CTROR !== 1'b1 || CELL_ADR !== 5'd1 || PINC !== 1'b1) begin errors++; $display("FAIL ovr_reoffer got %0h/%0d/%0b exp 1/1/1", CTROR, CELL_ADR, PINC); end
      CTR_ACK = 1'b1;
      step();
      CTR_ACK = 1'b0;
      step();
      step();
      step();
      checks++; if (CTROR !== 1'b0) begin errors++; $display("FAIL ovr_single got %0h exp 0", CTROR); end
   endtask

   task automatic test_reset_offer();
      REQ_PLUS[0]  = 1'b1;
      REQ_PLUS[4]  = 1'b1;
      REQ_MINUS[6] = 1'b1;
      step();
      REQ_PLUS  = '0;
      REQ_MINUS = '0;
      step();
      checks++; if (CTROR !== 1'b1 || CELL_ADR !== 5'd0 || PINC !== 1'b1) begin errors++; $display("FAIL rsto_offer got %0h/%0d/%0b exp 1/0/1", CTROR, CELL_ADR, PINC); end
      #2;
      SIM_RST_n = 1'b0;
      #1;
      checks++; if (CTROR !== 1'b0 || PINC !== 1'b0) begin errors++; $display("FAIL rsto_async got %0b%0b exp 00", CTROR, PINC); end
      step();
      step();
      SIM_RST_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++; if (CTROR !== 1'b0) begin errors++; $display("FAIL rsto_none cyc %0d got %0h exp 0", i, CTROR); end
      end
   endtask

   initial begin
      SIM_RST_n = 1'b0;
      REQ_PLUS  = '0;
      REQ_MINUS = '0;
      CTR_ACK   = 1'b0;
      OVR_CLR   = 1'b0;
      test_reset();
      test_single();
      test_priority();
      test_cancel();
      test_overrun();
      test_reset_offer();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
